// File: rtl/graphics_pkg.sv
// Shared graphics pipeline types.
//   vertex_t   : fp32 vertex, [VX]=x [VY]=y [VZ]=z [VW]=w
//   triangle_t : three vertices, [0] is the first vertex of the triangle
package graphics_pkg;

    typedef logic [3:0][31:0]      vertex_t;
    typedef logic [2:0][3:0][31:0] triangle_t;

    localparam int unsigned VX = 0;
    localparam int unsigned VY = 1;
    localparam int unsigned VZ = 2;
    localparam int unsigned VW = 3;

endpackage

// File: rtl/triangle_fifo.sv
// Synchronous FIFO of triangles with a registered head.
// The head entry and its valid flag come straight from flops and stay
// stable while the head is not popped.
// Ports:
//   clk_in, rst_in       : clock, asynchronous active-low reset
//   push_in, push_data_in: write request and triangle
//   pop_in               : consumer accepts head (ignored when empty)
//   full_out, empty_out  : occupancy flags
//   count_out            : triangles held
//   valid_out, head_out  : registered head of the FIFO
module triangle_fifo
    import graphics_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       push_in,
    input  triangle_t                  push_data_in,
    input  logic                       pop_in,
    output logic                       full_out,
    output logic                       empty_out,
    output logic [$clog2(DEPTH+1)-1:0] count_out,
    output logic                       valid_out,
    output triangle_t                  head_out
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    triangle_t         mem_q [DEPTH];
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     remaining;
    logic              valid_q, valid_d;
    triangle_t         head_q, head_d;
    logic              pop_ok, push_ok;

    assign empty_out = (count_q == '0);
    assign full_out  = (count_q == CW'(DEPTH));
    assign pop_ok    = pop_in && !empty_out;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign push_ok   = push_in && (!full_out || pop_ok);

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        head_d    = head_q;
        remaining = count_q - (pop_ok ? CW'(1) : CW'(0));

        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CW'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CW'(1);
        end

        // Next head: oldest surviving entry, else a push into an empty FIFO.
        if (remaining != '0) begin
            head_d = mem_q[rd_ptr_d];
        end else if (push_ok) begin
            head_d = push_data_in;
        end

        valid_d = (count_d != '0);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            head_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            head_q   <= head_d;
        end
    end

    // Storage needs no reset: only written entries are ever read.
    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_in;
        end
    end

    assign count_out = count_q;
    assign valid_out = valid_q;
    assign head_out  = head_q;

endmodule

// File: rtl/triangle_assembler.sv
// Groups the screen-space vertex stream into triangles and queues them for
// the rasterizer over a ready/valid handshake.
// Optional macro TRIANGLE_ASSEMBLER_STRIP_EN adds strip_in: with strip_in=1
// every vertex after the second completes a triangle, alternating winding.
// Ports:
//   clk_in, rst_in          : clock, asynchronous active-low reset
//   valid_in, vertex_in     : incoming vertex (no backpressure)
//   flush_in                : drop partial triangle, start a new primitive
//   strip_in                : strip mode for this vertex (macro only)
//   ready_in                : rasterizer accepts triangle_out
//   valid_out, triangle_out : head triangle
//   count_out               : triangles queued
//   overflow_out            : sticky, a completed triangle was dropped
module triangle_assembler
    import graphics_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       valid_in,
    input  vertex_t                    vertex_in,
    input  logic                       flush_in,
`ifdef TRIANGLE_ASSEMBLER_STRIP_EN
    input  logic                       strip_in,
`endif
    input  logic                       ready_in,
    output logic                       valid_out,
    output triangle_t                  triangle_out,
    output logic [$clog2(DEPTH+1)-1:0] count_out,
    output logic                       overflow_out
);

    // Vertex counter: which slot the next vertex fills.
    typedef enum logic [1:0] {
        StSlot0 = 2'd0,
        StSlot1 = 2'd1,
        StSlot2 = 2'd2
    } vc_e;

    vc_e       vc_q, vc_d;
    vertex_t   slot0_q, slot0_d;
    vertex_t   slot1_q, slot1_d;
    logic      overflow_q, overflow_d;
    logic      push;
    triangle_t tri_new;
    logic      fifo_full;
    logic      fifo_empty;
    logic      drop;
`ifdef TRIANGLE_ASSEMBLER_STRIP_EN
    logic      parity_q, parity_d;
`endif

    always_comb begin
        vc_d    = vc_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        push    = 1'b0;
        tri_new = '0;
`ifdef TRIANGLE_ASSEMBLER_STRIP_EN
        parity_d = parity_q;
`endif

        if (flush_in) begin
            // Flush wins over a completing vertex: it starts the new primitive.
            vc_d = StSlot0;
`ifdef TRIANGLE_ASSEMBLER_STRIP_EN
            parity_d = 1'b0;
`endif
            if (valid_in) begin
                slot0_d = vertex_in;
                vc_d    = StSlot1;
            end
        end else if (valid_in) begin
            unique case (vc_q)
                StSlot0: begin
                    slot0_d = vertex_in;
                    vc_d    = StSlot1;
                end
                StSlot1: begin
                    slot1_d = vertex_in;
                    vc_d    = StSlot2;
                end
                StSlot2: begin
                    push       = 1'b1;
                    tri_new[0] = slot0_q;
                    tri_new[1] = slot1_q;
                    tri_new[2] = vertex_in;
                    vc_d       = StSlot0;
`ifdef TRIANGLE_ASSEMBLER_STRIP_EN
                    parity_d   = 1'b0;
                    if (strip_in) begin
                        // Odd strip triangles swap the first two to keep winding.
                        if (parity_q) begin
                            tri_new[0] = slot1_q;
                            tri_new[1] = slot0_q;
                        end
                        slot0_d  = slot1_q;
                        slot1_d  = vertex_in;
                        vc_d     = StSlot2;
                        parity_d = !parity_q;
                    end
`endif
                end
                default: vc_d = StSlot0;
            endcase
        end
    end

    // Drop only when full and the head is not leaving on this edge.
    assign drop       = push && fifo_full && !(valid_out && ready_in);
    assign overflow_d = overflow_q || drop;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            vc_q       <= StSlot0;
            slot0_q    <= '0;
            slot1_q    <= '0;
            overflow_q <= 1'b0;
`ifdef TRIANGLE_ASSEMBLER_STRIP_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            vc_q       <= vc_d;
            slot0_q    <= slot0_d;
            slot1_q    <= slot1_d;
            overflow_q <= overflow_d;
`ifdef TRIANGLE_ASSEMBLER_STRIP_EN
            parity_q   <= parity_d;
`endif
        end
    end

    triangle_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .push_in     (push),
        .push_data_in(tri_new),
        .pop_in      (ready_in),
        .full_out    (fifo_full),
        .empty_out   (fifo_empty),
        .count_out   (count_out),
        .valid_out   (valid_out),
        .head_out    (triangle_out)
    );

    assign overflow_out = overflow_q;

    // Registered valid and the FIFO occupancy must always agree.
    assert property (@(posedge clk_in) disable iff (!rst_in) valid_out == !fifo_empty);

endmodule

// File: tb/tb_triangle_assembler.sv
module tb_triangle_assembler;
    import graphics_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic                       clk_in = 1'b0;
    logic                       rst_in = 1'b0;
    logic                       valid_in = 1'b0;
    vertex_t                    vertex_in = '0;
    logic                       flush_in = 1'b0;
    logic                       ready_in = 1'b0;
    logic                       valid_out;
    triangle_t                  triangle_out;
    logic [$clog2(DEPTH+1)-1:0] count_out;
    logic                       overflow_out;
`ifdef TRIANGLE_ASSEMBLER_STRIP_EN
    logic                       strip_in = 1'b0;
`endif

    triangle_assembler #(
        .DEPTH(DEPTH)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .valid_in    (valid_in),
        .vertex_in   (vertex_in),
        .flush_in    (flush_in),
`ifdef TRIANGLE_ASSEMBLER_STRIP_EN
        .strip_in    (strip_in),
`endif
        .ready_in    (ready_in),
        .valid_out   (valid_out),
        .triangle_out(triangle_out),
        .count_out   (count_out),
        .overflow_out(overflow_out)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: vertices of the current primitive, queued triangles.
    vertex_t   pend[$];
    triangle_t mq[$];
    bit        m_ovf = 1'b0;
    int        strip_k = 0;

    task automatic check(input string tag, input logic [383:0] got, input logic [383:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic vertex_t rand_vertex();
        vertex_t v;
        v[VX] = $urandom;
        v[VY] = $urandom;
        v[VZ] = $urandom;
        v[VW] = $urandom;
        return v;
    endfunction

    function automatic triangle_t mk_tri(input vertex_t a, input vertex_t b, input vertex_t c);
        triangle_t t;
        t[0] = a;
        t[1] = b;
        t[2] = c;
        return t;
    endfunction

    function automatic void model_reset();
        pend.delete();
        mq.delete();
        m_ovf   = 1'b0;
        strip_k = 0;
    endfunction

    // One clock edge of the specified behaviour, using pre-edge state.
    function automatic void model_edge(input bit v, input vertex_t vx, input bit fl, input bit rdy,
                                       input bit st);
        bit        pop = (mq.size() > 0) && rdy;
        bit        has = 1'b0;
        triangle_t t = '0;
        if (fl) begin
            pend.delete();
            strip_k = 0;
            if (v) pend.push_back(vx);
        end else if (v) begin
            pend.push_back(vx);
            if (pend.size() == 3) begin
                has = 1'b1;
                if (st) begin
                    t = (strip_k % 2 == 1) ? mk_tri(pend[1], pend[0], pend[2])
                                           : mk_tri(pend[0], pend[1], pend[2]);
                    void'(pend.pop_front());
                    strip_k++;
                end else begin
                    t = mk_tri(pend[0], pend[1], pend[2]);
                    pend.delete();
                    strip_k = 0;
                end
            end
        end
        if (pop) void'(mq.pop_front());
        if (has) begin
            if (mq.size() < DEPTH) mq.push_back(t);
            else m_ovf = 1'b1;
        end
    endfunction

    task automatic check_outputs();
        check("valid_out", valid_out, mq.size() > 0);
        check("count_out", count_out, mq.size());
        check("overflow_out", overflow_out, m_ovf);
        if (mq.size() > 0) check("triangle_out", triangle_out, mq[0]);
    endtask

    // Inputs change #1 after the rising edge; outputs checked #1 after the next one.
    task automatic step(input bit v, input vertex_t vx, input bit fl, input bit rdy, input bit st);
        valid_in  = v;
        vertex_in = vx;
        flush_in  = fl;
        ready_in  = rdy;
`ifdef TRIANGLE_ASSEMBLER_STRIP_EN
        strip_in  = st;
`endif
        @(posedge clk_in);
        model_edge(v, vx, fl, rdy, st);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        valid_in = 1'b0;
        flush_in = 1'b0;
        ready_in = 1'b0;
        rst_in   = 1'b0;
        #1;
        model_reset();
        check("rst_valid", valid_out, 1'b0);
        check("rst_count", count_out, 0);
        check("rst_ovf", overflow_out, 1'b0);
        check("rst_tri", triangle_out, 0);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
    endtask

    vertex_t xs[6];
    vertex_t va, vb, vc, vd, ve;

    initial begin
        xs[0] = '0; xs[0][VX] = 32'h3F800000;
        xs[1] = '0; xs[1][VX] = 32'h40000000;
        xs[2] = '0; xs[2][VX] = 32'h40400000;
        xs[3] = '0; xs[3][VX] = 32'h40800000;
        xs[4] = '0; xs[4][VX] = 32'h40A00000;
        xs[5] = '0; xs[5][VX] = 32'h40C00000;

        do_reset();

        // Two list triangles, ready held high.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, xs[i], 1'b0, 1'b1, 1'b0);
            if (i == 2 || i == 5) begin
                check("t1_valid_latency", valid_out, 1'b1);
                check("t1_x0", triangle_out[0][VX], xs[i-2][VX]);
                check("t1_x2", triangle_out[2][VX], xs[i][VX]);
            end
        end
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("t1_drained", valid_out, 1'b0);

        // Fill past capacity, then drain in order.
        for (int i = 0; i < 15; i++) step(1'b1, rand_vertex(), 1'b0, 1'b0, 1'b0);
        check("ovf_count_full", count_out, DEPTH);
        check("ovf_sticky", overflow_out, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("ovf_drained", count_out, 0);
        check("ovf_still_set", overflow_out, 1'b1);

        // Full FIFO: completing vertex coincides with a pop.
        do_reset();
        for (int i = 0; i < 14; i++) step(1'b1, rand_vertex(), 1'b0, 1'b0, 1'b0);
        step(1'b1, rand_vertex(), 1'b0, 1'b1, 1'b0);
        check("pushpop_count", count_out, DEPTH);
        check("pushpop_no_ovf", overflow_out, 1'b0);

        // Flush mid-triangle restarts with the flushing vertex.
        do_reset();
        va = rand_vertex(); vb = rand_vertex(); vc = rand_vertex();
        vd = rand_vertex(); ve = rand_vertex();
        step(1'b1, va, 1'b0, 1'b0, 1'b0);
        step(1'b1, vb, 1'b0, 1'b0, 1'b0);
        step(1'b1, vc, 1'b1, 1'b0, 1'b0);
        step(1'b1, vd, 1'b0, 1'b0, 1'b0);
        step(1'b1, ve, 1'b0, 1'b0, 1'b0);
        check("flush_count", count_out, 1);
        check("flush_tri", triangle_out, mk_tri(vc, vd, ve));

        // Async reset mid-triangle with two queued.
        for (int i = 0; i < 4; i++) step(1'b1, rand_vertex(), 1'b0, 1'b0, 1'b0);
        check("pre_rst_count", count_out, 2);
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, xs[i], 1'b0, 1'b0, 1'b0);
        check("post_rst_count", count_out, 1);
        check("post_rst_tri", triangle_out, mk_tri(xs[0], xs[1], xs[2]));

`ifdef TRIANGLE_ASSEMBLER_STRIP_EN
        // Strip of five vertices: three triangles with alternating winding.
        do_reset();
        step(1'b1, va, 1'b0, 1'b0, 1'b1);
        step(1'b1, vb, 1'b0, 1'b0, 1'b1);
        step(1'b1, vc, 1'b0, 1'b0, 1'b1);
        step(1'b1, vd, 1'b0, 1'b0, 1'b1);
        step(1'b1, ve, 1'b0, 1'b0, 1'b1);
        check("strip_count", count_out, 3);
        check("strip_t0", triangle_out, mk_tri(va, vb, vc));
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("strip_t1", triangle_out, mk_tri(vc, vb, vd));
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("strip_t2", triangle_out, mk_tri(vc, vd, ve));
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bit st = 1'b0;
`ifdef TRIANGLE_ASSEMBLER_STRIP_EN
            st = ($urandom_range(0, 1) == 1);
`endif
            step($urandom_range(0, 9) < 7, rand_vertex(), $urandom_range(0, 19) == 0,
                 $urandom_range(0, 1) == 1, st);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/triangle_assembler.md
Name: triangle_assembler

Overview:
- Sits directly downstream of the viewport stage.
- Consumes the screen-space vertex stream: one fp32 {w,z,y,x} vertex per valid pulse, no backpressure upstream.
- Groups vertices into triangles and buffers completed triangles in a small FIFO.
- Presents them to the rasterizer over a ready/valid handshake.

Parameters:
- DEPTH, 4: triangle FIFO depth in triangles; power of two, ≥2.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset; asynchronous, active-low (asserted when 0)
- valid_in  input  1  vertex_in valid this cycle; upstream cannot stall
- vertex_in  input  [3:0][31:0]  fp32 vertex, [0]=x [1]=y [2]=z [3]=w
- flush_in  input  1  discard partially assembled triangle / start new primitive
- ready_in  input  1  downstream accepts triangle_out
- valid_out  output  1  triangle_out holds FIFO head
- triangle_out  output  [2:0][3:0][31:0]  head triangle, [0] first vertex
- count_out  output  $clog2(DEPTH+1)  triangles in FIFO
- overflow_out  output  1  sticky: a completed triangle was dropped

Behaviour:
- Reset (rst_in=0, async):
  - valid_out=0, count_out=0, overflow_out=0, triangle_out=0.
  - Vertex counter=0, strip parity=0, FIFO pointers=0.
- Assembly (list mode):
  - 2-bit vertex counter vc ∈ {0,1,2}.
  - On valid_in: store vertex_in in slot[vc].
  - If vc<2, vc++.
  - If vc==2, form triangle {slot0, slot1, vertex_in}, request FIFO push on the same edge, vc←0.
  - Vertex data is bit-exact: no arithmetic or reordering within a vertex.
- FIFO:
  - Pop when valid_out && ready_in.
  - Push accepted if count<DEPTH, or if count==DEPTH and a pop occurs in the same cycle.
  - count_out updates each edge: +1 push only, −1 pop only, unchanged for both or neither.
- Latency: a triangle pushed into an empty FIFO appears with valid_out=1 on the cycle after the third vertex's valid_in.
- Output stability:
  - triangle_out and valid_out are registered.
  - Held stable while valid_out && !ready_in.
  - ready_in may toggle freely when valid_out=0.
- Overflow:
  - A push while full with no simultaneous pop drops the triangle.
  - On a drop, overflow_out←1 and stays 1 until reset.
  - vc still returns to 0; FIFO contents untouched.
- flush_in:
  - vc←0, parity←0; FIFO unaffected.
  - If valid_in in the same cycle, vertex_in becomes slot0 and vc←1.
  - Flush with vc==2 and valid_in: the flush wins, no triangle is formed.
- Empty FIFO: valid_out=0; ready_in is ignored.
- Simultaneous push into an empty FIFO and ready_in: no pop that cycle, since valid_out was 0.

Optional Feature:
- TRIANGLE_ASSEMBLER_STRIP_EN defined:
  - Adds input port strip_in (1 bit), sampled with each valid_in.
  - When strip_in=1 and vc==2, each vertex completes a triangle.
  - Even parity emits {slot0, slot1, v}; odd parity emits {slot1, slot0, v} to preserve winding.
  - After the emit: slot0←slot1, slot1←v, vc stays 2, parity toggles.
  - strip_in=0 behaves as list mode.
  - Changing strip_in between flushes is legal: each vertex uses its own sampled value.
- Undefined: no strip_in port, list mode only, parity logic absent.

Decomposition:
- graphics_pkg holds:
  - typedef vertex_t (logic [3:0][31:0]);
  - typedef triangle_t (logic [2:0][3:0][31:0]);
  - localparams VX=0, VY=1, VZ=2, VW=3.
- One sub-module: triangle_fifo, a synchronous FIFO of triangle_t.
  - Parameter DEPTH; push/pop/full/empty/count.
  - Same clk_in/rst_in convention.
- Assembly FSM, overflow and strip logic stay in triangle_assembler.

Test Plan:
- Six vertices x=1.0..6.0 (32'h3F800000…), ready_in=1 → two triangles, x={1,2,3} then {4,5,6}; each valid_out 1 cycle after the 3rd/6th vertex; overflow_out=0.
- ready_in=0, DEPTH=4, 15 vertices → count_out reaches 4, 5th triangle dropped, overflow_out=1 sticky. Then ready_in=1 → the first 4 triangles drain in order; count_out 4→0.
- Full FIFO, third vertex arrives in the same cycle as a pop → push accepted, count_out stays 4, overflow_out=0.
- Vertices A,B, then flush_in with C valid, then D,E → single triangle {C,D,E}.
- Async reset asserted mid-triangle with the FIFO holding 2 → all outputs 0 immediately. After release, 3 vertices → one triangle.
- With TRIANGLE_ASSEMBLER_STRIP_EN and strip_in=1, vertices A..E → triangles {A,B,C}, {C,B,D}, {C,D,E}.
